mode_controller_n: RTL and testbench

Parametrised successor to the drum machine's three-mode system controller: arbitrates one-hot-style mode requests from the front panel over `NUM_MODES` modes, with a per-mode enable mask. Every mode change goes through a quiesce handshake with the sequencer and audio path, so playback never switches mid-step. The block also tracks the previous mode and flags handshake timeouts. It sits between the panel debouncers and every mode-dependent block.

---
 rtl/mode_ctrl_pkg.sv | 14 +
 rtl/mode_prio_enc.sv | 22 ++
 rtl/mode_controller_n.sv | 118 +++++++++++
 tb/tb_mode_controller_n.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mode_ctrl_pkg.sv
// Shared types and constants for the drum machine mode controller.
package mode_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_STABLE = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_COMMIT = 2'd2
   } ctrl_state_t;

   localparam int unsigned MODE_EDIT = 0;
   localparam int unsigned MODE_PLAY = 1;
   localparam int unsigned MODE_RAW  = 2;

endpackage

// File: rtl/mode_prio_enc.sv
// Lowest-index-wins priority encoder over N request lines.
module mode_prio_enc #(
   parameter int N = 3,
   parameter int W = 2
) (
   input  logic [N-1:0] vec,
   output logic         hit,
   output logic [W-1:0] idx
);

   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!hit && vec[i]) begin
            hit = 1'b1;
            idx = W'(i);
         end
      end
   end

endmodule

// File: rtl/mode_controller_n.sv
// Mode request arbiter with quiesce handshake and drain timeout.
// Optional return-to-previous-mode request enabled by MODE_CTRL_RETURN_EN.
module mode_controller_n
   import mode_ctrl_pkg::*;
#(
   parameter int NUM_MODES     = 3,
   parameter int RESET_MODE    = 0,
   parameter int DRAIN_TIMEOUT = 255,
   localparam int MODE_W = ($clog2(NUM_MODES) > 1) ? $clog2(NUM_MODES) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_MODES-1:0] mode_req,
   input  logic [NUM_MODES-1:0] mode_mask,
   input  logic                 quiesce_ack,
`ifdef MODE_CTRL_RETURN_EN
   input  logic                 ret_req,
`endif
   output logic [MODE_W-1:0]    mode,
   output logic [MODE_W-1:0]    prev_mode,
   output logic                 mode_valid,
   output logic                 quiesce_req,
   output logic                 mode_changed,
   output logic                 timeout_err
);

   localparam int TMR_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

   ctrl_state_t       state_q, state_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic [MODE_W-1:0] prev_q, prev_d;
   logic [MODE_W-1:0] target_q, target_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              changed_q, changed_d;
   logic              terr_q, terr_d;

   logic              win_hit;
   logic [MODE_W-1:0] win_idx;
   logic              tmo;

   mode_prio_enc #(
      .N (NUM_MODES),
      .W (MODE_W)
   ) u_prio (
      .vec (mode_req & mode_mask),
      .hit (win_hit),
      .idx (win_idx)
   );

   assign tmo = (DRAIN_TIMEOUT > 0) && (timer_q == TMR_W'(DRAIN_TIMEOUT - 1));

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      prev_d    = prev_q;
      target_d  = target_q;
      timer_d   = timer_q;
      changed_d = 1'b0;
      terr_d    = terr_q;
      case (state_q)
         ST_STABLE: begin
            if (win_hit && (win_idx != mode_q)) begin
               target_d = win_idx;
               timer_d  = '0;
               state_d  = ST_DRAIN;
            end
`ifdef MODE_CTRL_RETURN_EN
            else if (!win_hit && ret_req && mode_mask[prev_q] && (prev_q != mode_q)) begin
               target_d = prev_q;
               timer_d  = '0;
               state_d  = ST_DRAIN;
            end
`endif
         end
         ST_DRAIN: begin
            timer_d = timer_q + 1'b1;
            if (quiesce_ack || tmo) begin
               mode_d    = target_q;
               prev_d    = mode_q;
               changed_d = 1'b1;
               state_d   = ST_COMMIT;
               // ack takes precedence, so only a pure timeout is an error
               if (!quiesce_ack) terr_d = 1'b1;
            end
         end
         ST_COMMIT: state_d = ST_STABLE;
         default:   state_d = ST_STABLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_STABLE;
         mode_q    <= MODE_W'(RESET_MODE);
         prev_q    <= MODE_W'(RESET_MODE);
         target_q  <= MODE_W'(RESET_MODE);
         timer_q   <= '0;
         changed_q <= 1'b0;
         terr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         prev_q    <= prev_d;
         target_q  <= target_d;
         timer_q   <= timer_d;
         changed_q <= changed_d;
         terr_q    <= terr_d;
      end
   end

   assign mode         = mode_q;
   assign prev_mode    = prev_q;
   assign mode_valid   = (state_q == ST_STABLE);
   assign quiesce_req  = (state_q == ST_DRAIN);
   assign mode_changed = changed_q;
   assign timeout_err  = terr_q;

endmodule

// File: tb/tb_mode_controller_n.sv
// Directed bench for mode_controller_n: vector table plus timeout, reset and return sequences.
module tb_mode_controller_n;
   import mode_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] mode_req;
   logic [2:0] mode_mask;
   logic       quiesce_ack;
`ifdef MODE_CTRL_RETURN_EN
   logic       ret_req;
`endif

   logic [1:0] mode, prev_mode;
   logic       mode_valid, quiesce_req, mode_changed, timeout_err;
   logic [1:0] t8_mode, t8_prev;
   logic       t8_valid, t8_qreq, t8_chg, t8_terr;
   logic [1:0] t0_mode, t0_prev;
   logic       t0_valid, t0_qreq, t0_chg, t0_terr;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   mode_controller_n #(.NUM_MODES(3), .RESET_MODE(0), .DRAIN_TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .mode_req(mode_req), .mode_mask(mode_mask),
      .quiesce_ack(quiesce_ack),
`ifdef MODE_CTRL_RETURN_EN
      .ret_req(ret_req),
`endif
      .mode(mode), .prev_mode(prev_mode), .mode_valid(mode_valid),
      .quiesce_req(quiesce_req), .mode_changed(mode_changed), .timeout_err(timeout_err));

   mode_controller_n #(.NUM_MODES(3), .RESET_MODE(0), .DRAIN_TIMEOUT(8)) dut_t8 (
      .clk(clk), .rst(rst), .mode_req(mode_req), .mode_mask(mode_mask),
      .quiesce_ack(quiesce_ack),
`ifdef MODE_CTRL_RETURN_EN
      .ret_req(ret_req),
`endif
      .mode(t8_mode), .prev_mode(t8_prev), .mode_valid(t8_valid),
      .quiesce_req(t8_qreq), .mode_changed(t8_chg), .timeout_err(t8_terr));

   mode_controller_n #(.NUM_MODES(3), .RESET_MODE(0), .DRAIN_TIMEOUT(0)) dut_t0 (
      .clk(clk), .rst(rst), .mode_req(mode_req), .mode_mask(mode_mask),
      .quiesce_ack(quiesce_ack),
`ifdef MODE_CTRL_RETURN_EN
      .ret_req(ret_req),
`endif
      .mode(t0_mode), .prev_mode(t0_prev), .mode_valid(t0_valid),
      .quiesce_req(t0_qreq), .mode_changed(t0_chg), .timeout_err(t0_terr));

   typedef struct {
      logic [2:0] req;
      logic [2:0] mask;
      logic       ack;
      logic [1:0] mode;
      logic [1:0] prev;
      logic       valid;
      logic       qreq;
      logic       chg;
   } vec_t;

   vec_t tv[21];

   function automatic vec_t mk(logic [2:0] r, logic [2:0] m, logic a, logic [1:0] md,
                               logic [1:0] pv, logic v, logic q, logic c);
      vec_t t;
      t.req = r; t.mask = m; t.ack = a; t.mode = md; t.prev = pv;
      t.valid = v; t.qreq = q; t.chg = c;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
   endtask

   initial begin
      int cnt;
      bit seen;
      rst = 1'b1;
      mode_req = '0;
      mode_mask = 3'b111;
      quiesce_ack = 1'b0;
`ifdef MODE_CTRL_RETURN_EN
      ret_req = 1'b0;
`endif
      #12 rst = 1'b0;
      chk("reset_state", {mode, prev_mode, mode_valid, quiesce_req, mode_changed, timeout_err},
          {2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0});

      // basic change to PLAY, ack in the fourth drain cycle
      tv[0]  = mk(3'b010, 3'b111, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
      tv[1]  = mk(3'b000, 3'b111, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
      tv[2]  = mk(3'b000, 3'b111, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
      tv[3]  = mk(3'b000, 3'b111, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
      tv[4]  = mk(3'b000, 3'b111, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1);
      tv[5]  = mk(3'b000, 3'b111, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
      // priority with mask: 110 & 101 -> RAW
      tv[6]  = mk(3'b110, 3'b101, 1'b0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0);
      tv[7]  = mk(3'b000, 3'b111, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1);
      tv[8]  = mk(3'b000, 3'b111, 1'b0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0);
      // minimum latency with ack already high
      tv[9]  = mk(3'b001, 3'b111, 1'b1, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0);
      tv[10] = mk(3'b000, 3'b111, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1);
      tv[11] = mk(3'b000, 3'b111, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0);
      // winner equal to current mode, then masked-out request
      tv[12] = mk(3'b011, 3'b111, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0);
      tv[13] = mk(3'b010, 3'b101, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0);
      // frozen target, then one stable cycle before the next transition
      tv[14] = mk(3'b010, 3'b111, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0);
      tv[15] = mk(3'b100, 3'b111, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0);
      tv[16] = mk(3'b100, 3'b111, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1);
      tv[17] = mk(3'b100, 3'b111, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
      tv[18] = mk(3'b100, 3'b111, 1'b0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0);
      tv[19] = mk(3'b000, 3'b111, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1);
      tv[20] = mk(3'b000, 3'b111, 1'b0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 21; i++) begin
         mode_req    = tv[i].req;
         mode_mask   = tv[i].mask;
         quiesce_ack = tv[i].ack;
         step();
         chk($sformatf("vec%0d", i),
             {mode, prev_mode, mode_valid, quiesce_req, mode_changed, timeout_err},
             {tv[i].mode, tv[i].prev, tv[i].valid, tv[i].qreq, tv[i].chg, 1'b0});
      end

      // timeout: no ack ever
      mode_req = '0; mode_mask = 3'b111; quiesce_ack = 1'b0;
      do_reset();
      mode_req = 3'b010;
      cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         mode_req = '0;
         if (t8_chg) begin
            seen = 1'b1;
            break;
         end
         if (t8_qreq) cnt++;
      end
      chk("t8_commit_seen", 32'(seen), 32'd1);
      chk("t8_drain_cycles", cnt, 32'd8);
      chk("t8_mode_prev", {t8_mode, t8_prev}, {2'd1, 2'd0});
      chk("t8_terr_set", 32'(t8_terr), 32'd1);
      for (int i = 0; i < 6; i++) step();
      chk("t8_terr_sticky", {t8_terr, t8_valid}, {1'b1, 1'b1});
      chk("t0_still_drain", {t0_qreq, t0_valid, t0_mode, t0_terr}, {1'b1, 1'b0, 2'd0, 1'b0});
      chk("t255_still_drain", {quiesce_req, timeout_err}, {1'b1, 1'b0});

      // asynchronous reset while draining
      #3 rst = 1'b1;
      #1;
      chk("rst_qreq_async", {quiesce_req, t0_qreq, mode_valid}, {1'b0, 1'b0, 1'b1});
      chk("rst_mode_async", {t8_mode, t8_prev, t8_terr}, {2'd0, 2'd0, 1'b0});
      #2 rst = 1'b0;

      // ack and timeout in the same cycle: ack wins
      mode_req = 3'b100;
      step();
      mode_req = '0;
      for (int i = 0; i < 7; i++) step();
      quiesce_ack = 1'b1;
      step();
      quiesce_ack = 1'b0;
      chk("tie_ack_wins", {t8_mode, t8_chg, t8_terr}, {2'd2, 1'b1, 1'b0});
      step();

`ifdef MODE_CTRL_RETURN_EN
      do_reset();
      quiesce_ack = 1'b1;
      mode_req = 3'b100;
      step();
      mode_req = '0;
      step();
      step();
      chk("ret_pre", {mode, prev_mode, mode_valid}, {2'd2, 2'd0, 1'b1});
      ret_req = 1'b1;
      step();
      ret_req = 1'b0;
      step();
      chk("ret_commit", {mode, prev_mode, mode_changed}, {2'd0, 2'd2, 1'b1});
      step();
      ret_req = 1'b1;
      mode_req = 3'b010;
      step();
      ret_req = 1'b0;
      mode_req = '0;
      step();
      chk("ret_req_loses", {mode, prev_mode}, {2'd1, 2'd0});
      quiesce_ack = 1'b0;
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
